dac_spi_rx: RTL and testbench
=============================

// Module: dac_spi_rx
// PURPOSE
//  Receiving end of the AD5662 3-wire DAC link (SYNC/SCLK/DIN). Sits on the DAC output pins,
//  or on a loopback of them, and rebuilds each 24-bit write frame into its 16-bit DAC code and
//  its 2-bit power-down field. Used for on-chip self-check of the DAC datapath and as the DAC
//  model in benches. Operates in the DAC's own dataclk domain.
// PARAMETERS
//  SYNC_STAGES  0   input synchronizer flops: 0 = same-domain tap, 2 = external pin loopback
//  FRAME_BITS   24  SCLK falling edges per frame, MSB first: 6 don't-care, PD[1:0], D[15:0]
// PORTS
//  dataclk      in   1   single clock; all logic on posedge
//  reset        in   1   synchronous, active-high
//  DAC_SYNC     in   1   frame strobe, active low
//  DAC_SCLK     in   1   serial clock; DIN is sampled on its falling edge
//  DAC_DIN      in   1   serial data, MSB first
//  data_out     out  16  D[15:0] of the last complete frame (offset binary)
//  pd_mode      out  2   PD[1:0] of the last complete frame
//  frame_valid  out  1   one-cycle pulse when data_out/pd_mode update
//  frame_error  out  1   one-cycle pulse when a frame is aborted
//  frame_count  out  16  complete frames received; wraps at 0xFFFF
// BEHAVIOUR
//  Input path
//   - DAC_SYNC/SCLK/DIN pass through SYNC_STAGES flops, then one sample register (s_*).
//   - sclk_prev holds the previous s_sclk.
//   - fall = sclk_prev & ~s_sclk, evaluated combinationally from registered values.
//  Reset: state=ARM; data_out=0, pd_mode=0, frame_valid=0, frame_error=0, frame_count=0;
//   shift register=0, bit_cnt=0, sclk_prev=0.
//  States
//   - ARM:   no frame is accepted. Go to IDLE when s_sync==1. This blocks a partial frame when
//            SYNC is already low at reset release.
//   - IDLE:  go to SHIFT when s_sync==0, with bit_cnt=0. A fall in that same cycle is shifted.
//   - SHIFT: on each fall with s_sync==0: sr <= {sr[22:0], s_din}; bit_cnt++.
//     - On the FRAME_BITS-th fall: data_out <= {sr[14:0],s_din}; pd_mode <= sr[16:15];
//       frame_valid=1; frame_count++; go to DONE.
//     - If s_sync==1 before FRAME_BITS falls: frame_error=1, outputs unchanged, go to IDLE.
//       With bit_cnt==0, SYNC rising is NOT an error (empty strobe) and just returns to IDLE.
//   - DONE:  any further falls are ignored, with no error. Go to IDLE on s_sync==1.
//  Edge/boundary rules
//   - Simultaneous fall and s_sync rise in SHIFT: SYNC wins; the bit is dropped (abort rule).
//   - frame_valid and frame_error are mutually exclusive; each lasts exactly one cycle.
//   - frame_count wraps 0xFFFF -> 0x0000 with no flag.
//   - Back-to-back frames need only one cycle of s_sync==1 between them.
//   - Reset mid-frame discards the partial frame; all outputs and state are as at reset.
//  Latency
//   - DAC_SCLK falls (pin, sampled at edge k); frame_valid/data_out are registered at edge
//     k+1+SYNC_STAGES.
//   - frame_error appears on the same schedule, measured from the DAC_SYNC rise.
//  Arithmetic: bit_cnt is 5 bits, unsigned. No data transform: data_out is the raw offset-binary
//   DAC code.
// TESTING
//  T1 one frame, PD=00, D=0x8000 -> 1-cycle frame_valid; data_out=0x8000, pd_mode=0,
//     frame_count 0->1.
//  T2 frame 0x1234 then frame 0xFFFF with PD=11, 1-cycle SYNC gap -> two pulses;
//     final data_out=0xFFFF, pd_mode=3, count=2.
//  T3 SYNC rises after 10 bits of 0xABCD -> frame_error for 1 cycle; data_out and count hold;
//     next full frame of 0x0001 is accepted.
//  T4 26 falls with SYNC held low, data 0x5A5A -> exactly one frame_valid; data_out=0x5A5A;
//     no error.
//  T5 reset asserted after 12 bits, then SYNC held low at release -> no frame accepted until
//     SYNC goes high; next frame 0x00FF gives data_out=0x00FF, count=1.
//  T6 preload count 0xFFFF via 65535 frames (or force), send 1 frame -> frame_count=0x0000;
//     frame_valid pulses. Run at SYNC_STAGES=0 and 2; check that latency is k+1+SYNC_STAGES.

Source files
------------

// File: rtl/dac_spi_rx.sv
// Receive side of the AD5662 SYNC/SCLK/DIN link: rebuilds each write frame into its
// 16-bit DAC code and 2-bit power-down field, in the DAC's own dataclk domain.
module dac_spi_rx #(
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned FRAME_BITS  = 24
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic        DAC_SYNC,
  input  logic        DAC_SCLK,
  input  logic        DAC_DIN,
  output logic [15:0] data_out,
  output logic [1:0]  pd_mode,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [15:0] frame_count
);

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PD_W    = 2;
  localparam int unsigned COUNT_W = 16;
  // Only the trailing PD+D bits of a frame are kept; the current DIN completes the word.
  localparam int unsigned SR_W    = DATA_W + PD_W - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  logic sync_pin;
  logic sclk_pin;
  logic din_pin;

  generate
    if (SYNC_STAGES == 0) begin : g_tap
      assign sync_pin = DAC_SYNC;
      assign sclk_pin = DAC_SCLK;
      assign din_pin  = DAC_DIN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_ff;
      logic [SYNC_STAGES-1:0] sclk_ff;
      logic [SYNC_STAGES-1:0] din_ff;

      // Synchronizer chains reset low so SYNC never looks released before the pin says so.
      always_ff @(posedge dataclk) begin
        if (reset) begin
          sync_ff <= '0;
          sclk_ff <= '0;
          din_ff  <= '0;
        end else begin
          sync_ff[0] <= DAC_SYNC;
          sclk_ff[0] <= DAC_SCLK;
          din_ff[0]  <= DAC_DIN;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_ff[i] <= sync_ff[i-1];
            sclk_ff[i] <= sclk_ff[i-1];
            din_ff[i]  <= din_ff[i-1];
          end
        end
      end

      assign sync_pin = sync_ff[SYNC_STAGES-1];
      assign sclk_pin = sclk_ff[SYNC_STAGES-1];
      assign din_pin  = din_ff[SYNC_STAGES-1];
    end
  endgenerate

  logic s_sync;
  logic s_sclk;
  logic s_din;
  logic sclk_prev;
  logic fall;

  always_ff @(posedge dataclk) begin
    if (reset) begin
      s_sync    <= 1'b0;
      s_sclk    <= 1'b0;
      s_din     <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      s_sync    <= sync_pin;
      s_sclk    <= sclk_pin;
      s_din     <= din_pin;
      sclk_prev <= s_sclk;
    end
  end

  assign fall = sclk_prev & ~s_sclk;

  state_t             state;
  state_t             state_d;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_d;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_d;
  logic [DATA_W-1:0]  data_d;
  logic [PD_W-1:0]    pd_d;
  logic               valid_d;
  logic               error_d;
  logic [COUNT_W-1:0] count_d;

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state       <= ARM;
      sr          <= '0;
      bit_cnt     <= '0;
      data_out    <= '0;
      pd_mode     <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_d;
      sr          <= sr_d;
      bit_cnt     <= bit_cnt_d;
      data_out    <= data_d;
      pd_mode     <= pd_d;
      frame_valid <= valid_d;
      frame_error <= error_d;
      frame_count <= count_d;
    end
  end

  // Frame tracking: SYNC rise always wins over a coincident SCLK fall.
  always_comb begin
    state_d   = state;
    sr_d      = sr;
    bit_cnt_d = bit_cnt;
    data_d    = data_out;
    pd_d      = pd_mode;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    count_d   = frame_count;

    case (state)
      ARM: begin
        if (s_sync) state_d = IDLE;
      end
      IDLE: begin
        if (!s_sync) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          if (fall) begin
            sr_d      = {sr[SR_W-2:0], s_din};
            bit_cnt_d = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (s_sync) begin
          state_d   = IDLE;
          error_d   = (bit_cnt != '0);
          bit_cnt_d = '0;
        end else if (fall) begin
          sr_d = {sr[SR_W-2:0], s_din};
          if (bit_cnt == LAST_BIT) begin
            data_d    = {sr[DATA_W-2:0], s_din};
            pd_d      = sr[SR_W-1 -: PD_W];
            valid_d   = 1'b1;
            count_d   = frame_count + COUNT_W'(1);
            bit_cnt_d = '0;
            state_d   = DONE;
          end else begin
            bit_cnt_d = bit_cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (s_sync) state_d = IDLE;
      end
      default: state_d = ARM;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_rx.sv
// Scoreboard bench for dac_spi_rx: same pin stimulus drives a same-domain tap and a
// two-flop loopback instance; each has its own expected-event queue and monitor.
module tb_dac_spi_rx;

  typedef struct {
    logic        is_err;
    logic [15:0] data;
    logic [1:0]  pd;
    logic [15:0] count;
    int          base;
  } exp_t;

  logic dataclk;
  logic reset;
  logic DAC_SYNC;
  logic DAC_SCLK;
  logic DAC_DIN;

  logic [15:0] data0, count0, data2, count2;
  logic [1:0]  pd0, pd2;
  logic        v0, e0, v2, e2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q2[$];

  logic [15:0] exp_data;
  logic [1:0]  exp_pd;
  logic [15:0] exp_count;

  dac_spi_rx #(.SYNC_STAGES(0), .FRAME_BITS(24)) u0 (
    .dataclk(dataclk), .reset(reset), .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK),
    .DAC_DIN(DAC_DIN), .data_out(data0), .pd_mode(pd0), .frame_valid(v0),
    .frame_error(e0), .frame_count(count0)
  );

  dac_spi_rx #(.SYNC_STAGES(2), .FRAME_BITS(24)) u2 (
    .dataclk(dataclk), .reset(reset), .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK),
    .DAC_DIN(DAC_DIN), .data_out(data2), .pd_mode(pd2), .frame_valid(v2),
    .frame_error(e2), .frame_count(count2)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;
  always @(posedge dataclk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge dataclk);
    #1;
  endtask

  task automatic push_exp(input logic is_err, input int base);
    exp_t x;
    x.is_err = is_err;
    x.data   = exp_data;
    x.pd     = exp_pd;
    x.count  = exp_count;
    x.base   = base;
    q0.push_back(x);
    q2.push_back(x);
  endtask

  // Pops the next expected event for one instance; latency is 2+stages from the pin edge.
  task automatic check_evt(input int d, input logic v, input logic e, input logic [15:0] data,
                           input logic [1:0] pd, input logic [15:0] cnt);
    exp_t x;
    int   stages;
    stages = (d == 0) ? 0 : 2;
    if ((d == 0 && q0.size() == 0) || (d != 0 && q2.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected_event valid=%0b error=%0b at cycle %0d", d, v, e, cyc);
      return;
    end
    if (d == 0) x = q0.pop_front();
    else        x = q2.pop_front();
    cmp($sformatf("dut%0d kind", d), {30'd0, v, e}, x.is_err ? 32'd1 : 32'd2);
    cmp($sformatf("dut%0d data_out", d), {16'd0, data}, {16'd0, x.data});
    cmp($sformatf("dut%0d pd_mode", d), {30'd0, pd}, {30'd0, x.pd});
    cmp($sformatf("dut%0d frame_count", d), {16'd0, cnt}, {16'd0, x.count});
    cmp($sformatf("dut%0d latency_cycle", d), 32'(cyc), 32'(x.base + 2 + stages));
  endtask

  always @(negedge dataclk) if (!reset && (v0 || e0)) check_evt(0, v0, e0, data0, pd0, count0);
  always @(negedge dataclk) if (!reset && (v2 || e2)) check_evt(2, v2, e2, data2, pd2, count2);

  // Sends n bits MSB-first from w[31]; pushes a valid event at the mark-th SCLK fall.
  task automatic shift_bits(input logic [31:0] w, input int n, input int mark);
    logic [31:0] word;
    word = w;
    for (int j = 0; j < n; j++) begin
      DAC_DIN  = word[31-j];
      DAC_SCLK = 1'b1;
      clk_wait(2);
      DAC_SCLK = 1'b0;
      if (j + 1 == mark) push_exp(1'b0, cyc);
      clk_wait(2);
    end
  endtask

  task automatic send_frame(input logic [1:0] pd, input logic [15:0] d, input int gap);
    exp_data  = d;
    exp_pd    = pd;
    exp_count = exp_count + 16'd1;
    DAC_SYNC  = 1'b0;
    clk_wait(2);
    shift_bits({6'h2A, pd, d, 8'h00}, 24, 24);
    DAC_SYNC = 1'b1;
    clk_wait(gap);
  endtask

  task automatic check_outputs(input string tag);
    cmp({tag, " data_out u0"}, {16'd0, data0}, {16'd0, exp_data});
    cmp({tag, " data_out u2"}, {16'd0, data2}, {16'd0, exp_data});
    cmp({tag, " pd_mode u0"}, {30'd0, pd0}, {30'd0, exp_pd});
    cmp({tag, " pd_mode u2"}, {30'd0, pd2}, {30'd0, exp_pd});
    cmp({tag, " frame_count u0"}, {16'd0, count0}, {16'd0, exp_count});
    cmp({tag, " frame_count u2"}, {16'd0, count2}, {16'd0, exp_count});
    cmp({tag, " pulses u0"}, {30'd0, v0, e0}, 32'd0);
    cmp({tag, " pulses u2"}, {30'd0, v2, e2}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    DAC_SYNC  = 1'b1;
    DAC_SCLK  = 1'b0;
    DAC_DIN   = 1'b0;
    exp_data  = 16'h0000;
    exp_pd    = 2'b00;
    exp_count = 16'h0000;
    clk_wait(4);
    @(negedge dataclk);
    check_outputs("reset");
    clk_wait(1);
    reset = 1'b0;
    clk_wait(6);

    // T1 single frame
    send_frame(2'b00, 16'h8000, 4);
    // T2 back-to-back with a one-cycle SYNC gap
    send_frame(2'b00, 16'h1234, 1);
    send_frame(2'b11, 16'hFFFF, 4);

    // T3 abort after 10 bits, then a good frame
    DAC_SYNC = 1'b0;
    clk_wait(2);
    shift_bits({6'h2A, 2'b00, 16'hABCD, 8'h00}, 10, 0);
    DAC_SYNC = 1'b1;
    push_exp(1'b1, cyc);
    clk_wait(4);
    send_frame(2'b01, 16'h0001, 4);

    // Empty strobe: no event
    DAC_SYNC = 1'b0;
    clk_wait(3);
    DAC_SYNC = 1'b1;
    clk_wait(4);

    // SCLK fall coincident with SYNC rise: abort, bit dropped
    DAC_SYNC = 1'b0;
    clk_wait(2);
    shift_bits({6'h2A, 2'b10, 16'h7777, 8'h00}, 5, 0);
    DAC_DIN  = 1'b1;
    DAC_SCLK = 1'b1;
    clk_wait(2);
    DAC_SCLK = 1'b0;
    DAC_SYNC = 1'b1;
    push_exp(1'b1, cyc);
    clk_wait(4);

    // T4 26 falls under one SYNC: only the first 24 count
    exp_data  = 16'h5A5A;
    exp_pd    = 2'b10;
    exp_count = exp_count + 16'd1;
    DAC_SYNC  = 1'b0;
    clk_wait(2);
    shift_bits({6'h2A, 2'b10, 16'h5A5A, 2'b11, 6'h00}, 26, 24);
    DAC_SYNC = 1'b1;
    clk_wait(6);
    @(negedge dataclk);
    check_outputs("after_t4");
    clk_wait(1);

    // T5 reset mid-frame with SYNC held low through release
    DAC_SYNC = 1'b0;
    clk_wait(2);
    shift_bits({6'h2A, 2'b01, 16'hCAFE, 8'h00}, 12, 0);
    reset = 1'b1;
    clk_wait(3);
    exp_data  = 16'h0000;
    exp_pd    = 2'b00;
    exp_count = 16'h0000;
    @(negedge dataclk);
    check_outputs("mid_reset");
    clk_wait(1);
    reset = 1'b0;
    shift_bits({6'h2A, 2'b01, 16'hBEEF, 8'h00}, 24, 0);
    DAC_SYNC = 1'b1;
    clk_wait(3);
    send_frame(2'b00, 16'h00FF, 4);

    // T6 counter wrap from a preloaded 0xFFFF
    @(negedge dataclk);
    force u0.frame_count = 16'hFFFF;
    force u2.frame_count = 16'hFFFF;
    @(negedge dataclk);
    release u0.frame_count;
    release u2.frame_count;
    exp_count = 16'hFFFF;
    clk_wait(2);
    send_frame(2'b00, 16'h4321, 4);
    send_frame(2'b11, 16'h0F0F, 4);

    clk_wait(20);
    @(negedge dataclk);
    check_outputs("final");
    cmp("q0 drained", 32'(q0.size()), 32'd0);
    cmp("q2 drained", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
